mac_result_packer: RTL and testbench

- Sits directly downstream of the FP MAC stage in the tensor-core datapath.
- Accepts one 32-bit MAC result per cycle, together with its exception flags (NV/OF/UF/NX).
- Packs results into 128-bit lines: 8 fp16 lanes in mode 00, 4 fp32 lanes in modes 01/10.
- Buffers completed lines in a small FIFO with valid/ready toward the writeback path, and keeps per-line and sticky exception flags.

---
 rtl/tc_pkg.sv | 33 +++
 rtl/mac_line_fifo.sv | 70 +++++++
 rtl/mac_result_packer.sv | 144 ++++++++++++++
 tb/tb_mac_result_packer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// rtl/tc_pkg.sv - shared types and constants for the tensor-core result path
package tc_pkg;

    localparam int TC_LINE_W  = 128;
    localparam int LANES_FP16 = 8;
    localparam int LANES_FP32 = 4;

    typedef enum logic [1:0] {
        MODE_FP16 = 2'b00,
        MODE_MIX  = 2'b01,
        MODE_FP32 = 2'b10
    } mode_e;

    typedef struct packed {
        logic nv;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    typedef struct packed {
        logic [TC_LINE_W-1:0] data;
        logic [3:0]           count;
        mode_e                mode;
        fflags_t              flags;
    } line_t;

    // Encoding 2'b11 has no format of its own and packs like fp32.
    function automatic mode_e norm_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_FP32 : mode_e'(m);
    endfunction

endpackage

// File: rtl/mac_line_fifo.sv
// rtl/mac_line_fifo.sv - synchronous FIFO of packed result lines
module mac_line_fifo
    import tc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  rst,          // asynchronous, active-low
    input  logic  push_i,       // write push_line_i (ignored when full)
    input  line_t push_line_i,
    input  logic  pop_i,        // drop head entry (ignored when empty)
    output line_t head_o,       // head entry, zero when empty
    output logic  valid_o,      // FIFO not empty
    output logic  full_o        // FIFO full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    line_t           mem_q [DEPTH];
    line_t           mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push_i && !full_o;
        do_pop   = pop_i && valid_o;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_line_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mac_result_packer.sv
// rtl/mac_result_packer.sv - packs MAC results into 128-bit lines behind a line FIFO
module mac_result_packer
    import tc_pkg::*;
#(
    parameter int LINE_W     = 128,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,            // asynchronous, active-low
    input  logic [1:0]        mode_i,         // 00 fp16, 01 mix, 10/11 fp32
    input  logic              res_valid_i,
    output logic              res_ready_o,
    input  logic [31:0]       res_data_i,
    input  logic              res_last_i,     // close the line after this result
    input  logic              NV_i,
    input  logic              OF_i,
    input  logic              UF_i,
    input  logic              NX_i,
    output logic              line_valid_o,
    input  logic              line_ready_i,
    output logic [LINE_W-1:0] line_data_o,
    output logic [3:0]        line_count_o,
    output logic [1:0]        line_mode_o,
    output logic [3:0]        line_flags_o,   // {NV,OF,UF,NX}
    input  logic              clr_flags_i,
    output logic [3:0]        sticky_flags_o  // {NV,OF,UF,NX}
);

    logic [TC_LINE_W-1:0] asm_q, asm_d;
    logic [3:0]           cnt_q, cnt_d;
    mode_e                line_mode_q, line_mode_d;
    fflags_t              line_flags_q, line_flags_d;
    fflags_t              sticky_q, sticky_d;

    mode_e                mode_n;
    fflags_t              in_flags;
    fflags_t              flags_acc;
    logic                 mode_chg;
    logic                 acc;
    logic [3:0]           lanes;
    logic [3:0]           cnt_inc;
    logic [TC_LINE_W-1:0] ins_data;

    logic                 fifo_full;
    logic                 push;
    line_t                push_line;
    line_t                head;

    assign mode_n   = norm_mode(mode_i);
    assign in_flags = {NV_i, OF_i, UF_i, NX_i};

    // A result in a different format cannot join a partial line: this cycle
    // the partial line is flushed instead and the result waits one cycle.
    assign mode_chg    = res_valid_i && (cnt_q != 4'd0) && (mode_n != line_mode_q);
    assign res_ready_o = !fifo_full && !mode_chg;
    assign acc         = res_valid_i && res_ready_o;

    assign lanes     = (mode_n == MODE_FP16) ? 4'(LANES_FP16) : 4'(LANES_FP32);
    assign cnt_inc   = cnt_q + 4'd1;
    assign flags_acc = line_flags_q | in_flags;

    always_comb begin
        ins_data = asm_q;
        if (mode_n == MODE_FP16) begin
            ins_data[{cnt_q[2:0], 4'b0000} +: 16] = res_data_i[15:0];
        end else begin
            ins_data[{cnt_q[1:0], 5'b00000} +: 32] = res_data_i;
        end
    end

    always_comb begin
        asm_d        = asm_q;
        cnt_d        = cnt_q;
        line_mode_d  = line_mode_q;
        line_flags_d = line_flags_q;
        push         = 1'b0;
        push_line    = '0;

        if (mode_chg && !fifo_full) begin
            push      = 1'b1;
            push_line = '{data: asm_q, count: cnt_q, mode: line_mode_q, flags: line_flags_q};
            asm_d        = '0;
            cnt_d        = 4'd0;
            line_flags_d = '0;
        end else if (acc) begin
            if ((cnt_inc == lanes) || res_last_i) begin
                push      = 1'b1;
                push_line = '{data: ins_data, count: cnt_inc, mode: mode_n, flags: flags_acc};
                asm_d        = '0;
                cnt_d        = 4'd0;
                line_flags_d = '0;
            end else begin
                asm_d        = ins_data;
                cnt_d        = cnt_inc;
                line_flags_d = flags_acc;
            end
            line_mode_d = mode_n;
        end
    end

    // A clear coinciding with an accept keeps only the new element's flags.
    always_comb begin
        sticky_d = clr_flags_i ? '0 : sticky_q;
        if (acc) begin
            sticky_d = sticky_d | in_flags;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asm_q        <= '0;
            cnt_q        <= 4'd0;
            line_mode_q  <= MODE_FP16;
            line_flags_q <= '0;
            sticky_q     <= '0;
        end else begin
            asm_q        <= asm_d;
            cnt_q        <= cnt_d;
            line_mode_q  <= line_mode_d;
            line_flags_q <= line_flags_d;
            sticky_q     <= sticky_d;
        end
    end

    mac_line_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_line_i (push_line),
        .pop_i       (line_valid_o && line_ready_i),
        .head_o      (head),
        .valid_o     (line_valid_o),
        .full_o      (fifo_full)
    );

    assign line_data_o    = head.data;
    assign line_count_o   = head.count;
    assign line_mode_o    = head.mode;
    assign line_flags_o   = head.flags;
    assign sticky_flags_o = sticky_q;

endmodule

// File: tb/tb_mac_result_packer.sv
// tb/tb_mac_result_packer.sv - directed self-checking bench for mac_result_packer
module tb_mac_result_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   mode_i;
    logic         res_valid_i;
    logic         res_ready_o;
    logic [31:0]  res_data_i;
    logic         res_last_i;
    logic         NV_i, OF_i, UF_i, NX_i;
    logic         line_valid_o;
    logic         line_ready_i;
    logic [127:0] line_data_o;
    logic [3:0]   line_count_o;
    logic [1:0]   line_mode_o;
    logic [3:0]   line_flags_o;
    logic         clr_flags_i;
    logic [3:0]   sticky_flags_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mac_result_packer #(
        .LINE_W     (128),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mode_i         (mode_i),
        .res_valid_i    (res_valid_i),
        .res_ready_o    (res_ready_o),
        .res_data_i     (res_data_i),
        .res_last_i     (res_last_i),
        .NV_i           (NV_i),
        .OF_i           (OF_i),
        .UF_i           (UF_i),
        .NX_i           (NX_i),
        .line_valid_o   (line_valid_o),
        .line_ready_i   (line_ready_i),
        .line_data_o    (line_data_o),
        .line_count_o   (line_count_o),
        .line_mode_o    (line_mode_o),
        .line_flags_o   (line_flags_o),
        .clr_flags_i    (clr_flags_i),
        .sticky_flags_o (sticky_flags_o)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered and left at posedge+1; returns just after the accepting edge.
    task automatic send(input logic [1:0] m, input logic [31:0] d, input logic last,
                        input logic [3:0] f);
        int n;
        n = 0;
        mode_i      = m;
        res_data_i  = d;
        res_last_i  = last;
        {NV_i, OF_i, UF_i, NX_i} = f;
        res_valid_i = 1'b1;
        #1;
        while (!res_ready_o && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!res_ready_o) check("send_timeout", res_ready_o, 1);
        @(posedge clk);
        #1;
        res_valid_i = 1'b0;
        res_last_i  = 1'b0;
        {NV_i, OF_i, UF_i, NX_i} = 4'b0000;
    endtask

    // Waits for a head line, compares every field, then pops it.
    task automatic expect_line(input string tag, input logic [127:0] d, input logic [3:0] c,
                               input logic [1:0] m, input logic [3:0] f);
        int n;
        n = 0;
        while (!line_valid_o && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_valid"}, line_valid_o, 1);
        check({tag, "_data"},  line_data_o,  d);
        check({tag, "_count"}, line_count_o, c);
        check({tag, "_mode"},  line_mode_o,  m);
        check({tag, "_flags"}, line_flags_o, f);
        line_ready_i = 1'b1;
        @(posedge clk);
        #1;
        line_ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b0;
        mode_i       = 2'b00;
        res_valid_i  = 1'b0;
        res_data_i   = 32'h0;
        res_last_i   = 1'b0;
        {NV_i, OF_i, UF_i, NX_i} = 4'b0000;
        line_ready_i = 1'b0;
        clr_flags_i  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid",  line_valid_o,   0);
        check("rst_data",   line_data_o,    0);
        check("rst_count",  line_count_o,   0);
        check("rst_mode",   line_mode_o,    0);
        check("rst_flags",  line_flags_o,   0);
        check("rst_sticky", sticky_flags_o, 0);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", res_ready_o, 1);

        // fp16 fill with the consumer always ready; upper 16 bits are junk.
        line_ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send(2'b00, {16'hDEAD, 16'(i)}, 1'b0, 4'b0000);
            if (i == 7) check("fill_not_early", line_valid_o, 0);
        end
        check("fill_valid", line_valid_o, 1);
        check("fill_data",  line_data_o, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        check("fill_count", line_count_o, 8);
        check("fill_mode",  line_mode_o, 0);
        @(posedge clk);
        #1;
        line_ready_i = 1'b0;
        check("fill_popped", line_valid_o, 0);

        // fp32 partial line closed by last
        send(2'b10, 32'h3F80_0000, 1'b0, 4'b0000);
        send(2'b10, 32'h4000_0000, 1'b0, 4'b0000);
        send(2'b10, 32'h4040_0000, 1'b1, 4'b0000);
        expect_line("last", 128'h0000_0000_4040_0000_4000_0000_3F80_0000, 3, 2'b10, 4'b0000);

        // mode change flushes the partial fp16 line for one cycle
        send(2'b00, 32'h0000_0001, 1'b0, 4'b0000);
        send(2'b00, 32'h0000_0002, 1'b0, 4'b0000);
        mode_i      = 2'b10;
        res_data_i  = 32'h1111_1111;
        res_valid_i = 1'b1;
        #1;
        check("mc_ready_low", res_ready_o, 0);
        check("mc_no_line_yet", line_valid_o, 0);
        @(posedge clk);
        #2;
        check("mc_ready_back", res_ready_o, 1);
        check("mc_flushed", line_valid_o, 1);
        @(posedge clk);
        #1;
        res_valid_i = 1'b0;
        expect_line("mc_partial", 128'h0002_0001, 2, 2'b00, 4'b0000);
        send(2'b11, 32'h2222_2222, 1'b1, 4'b0000);
        expect_line("mc_fp32", {64'h0, 32'h2222_2222, 32'h1111_1111}, 2, 2'b10, 4'b0000);

        // backpressure: two full lines fill the FIFO, then inputs stall
        for (int i = 0; i < 8; i++) begin
            send(2'b10, 32'hA000_0000 + 32'(i), 1'b0, 4'b0000);
        end
        mode_i      = 2'b10;
        res_data_i  = 32'hA000_0008;
        res_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_ready_low", res_ready_o, 0);
            check("bp_head_stable", line_data_o,
                  {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000});
            @(posedge clk);
            #1;
        end
        res_valid_i = 1'b0;
        expect_line("bp0", {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000},
                    4, 2'b10, 4'b0000);
        for (int i = 8; i < 12; i++) begin
            send(2'b10, 32'hA000_0000 + 32'(i), 1'b0, 4'b0000);
        end
        expect_line("bp1", {32'hA000_0007, 32'hA000_0006, 32'hA000_0005, 32'hA000_0004},
                    4, 2'b10, 4'b0000);
        expect_line("bp2", {32'hA000_000B, 32'hA000_000A, 32'hA000_0009, 32'hA000_0008},
                    4, 2'b10, 4'b0000);

        // flags: OF on element 2, then clear together with an NX accept
        send(2'b10, 32'h0000_0011, 1'b0, 4'b0000);
        send(2'b10, 32'h0000_0022, 1'b0, 4'b0100);
        send(2'b10, 32'h0000_0033, 1'b0, 4'b0000);
        send(2'b10, 32'h0000_0044, 1'b0, 4'b0000);
        check("flag_sticky", sticky_flags_o, 4'b0100);
        expect_line("flag", {32'h44, 32'h33, 32'h22, 32'h11}, 4, 2'b10, 4'b0100);
        clr_flags_i = 1'b1;
        send(2'b10, 32'h0000_0005, 1'b1, 4'b0001);
        clr_flags_i = 1'b0;
        check("clr_acc_sticky", sticky_flags_o, 4'b0001);
        expect_line("clr_line", 128'h5, 1, 2'b10, 4'b0001);
        clr_flags_i = 1'b1;
        @(posedge clk);
        #1;
        clr_flags_i = 1'b0;
        check("clr_only_sticky", sticky_flags_o, 4'b0000);

        // asynchronous reset with a buffered line and a partial line
        send(2'b10, 32'hCAFE_F00D, 1'b1, 4'b0000);
        send(2'b00, 32'h0000_0001, 1'b0, 4'b1000);
        send(2'b00, 32'h0000_0002, 1'b0, 4'b0000);
        send(2'b00, 32'h0000_0003, 1'b0, 4'b0000);
        check("mid_pre_valid", line_valid_o, 1);
        check("mid_pre_sticky", sticky_flags_o, 4'b1000);
        #2;
        rst = 1'b0;
        #1;
        check("mid_valid",  line_valid_o,   0);
        check("mid_data",   line_data_o,    0);
        check("mid_count",  line_count_o,   0);
        check("mid_mode",   line_mode_o,    0);
        check("mid_flags",  line_flags_o,   0);
        check("mid_sticky", sticky_flags_o, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_still_empty", line_valid_o, 0);
        send(2'b00, 32'h0000_00AA, 1'b1, 4'b0000);
        expect_line("mid_lane0", 128'hAA, 1, 2'b00, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
